mem_write_checker: RTL and testbench
====================================

# mem_write_checker

Synthesizable, self-checking bus monitor for the MIPS multi-cycle core: watches the data-memory write port (`memwrite`, `dataadr`, `writedata`) and decides PASS/FAIL against a table of expected address/data writes. It generalises the single-write check used in simulation to N checkpoints, in-order or any-order matching, a cycle timeout and a failure report. It sits beside the core top, on FPGA or in benches, and drives status LEDs or the bench stop condition.

## Interface
- `ADDR_W`, 32, memory address width
- `DATA_W`, 32, write data width
- `NUM_CHECKS`, 4, number of expected writes (≥1)
- `IN_ORDER`, 1, 1 = checkpoints must occur in table order; 0 = any order
- `TIMEOUT`, 4096, RUN cycles allowed before timeout fail (≥2)
- `clk  in  1  clock; all logic on rising edge`
- `reset  in  1  synchronous, active-high reset`
- `start  in  1  arm checker; latches expected table`
- `memwrite  in  1  core memory write strobe`
- `dataadr  in  ADDR_W  write address`
- `writedata  in  DATA_W  write data`
- `exp_addr  in  NUM_CHECKS*ADDR_W  expected addresses, entry i at [i*ADDR_W +: ADDR_W]`
- `exp_data  in  NUM_CHECKS*DATA_W  expected data, same packing`
- `done  out  1  PASS or FAIL reached (sticky)`
- `pass  out  1  all checkpoints matched`
- `fail  out  1  mismatch or timeout`
- `fail_code  out  2  0 none, 1 data mismatch, 2 timeout`
- `fail_addr  out  ADDR_W  address of offending write (0 on timeout)`
- `fail_data  out  DATA_W  data of offending write (0 on timeout)`
- `match_cnt  out  $clog2(NUM_CHECKS+1)  checkpoints matched so far`

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset → IDLE; every output 0.
- IDLE/PASS/FAIL + `start` → RUN: latch `exp_addr`/`exp_data`, clear `match_cnt`, hit bitmap, timeout counter, `fail_*`, `done`, `pass`, `fail`. `start` during RUN ignored.
- RUN, write sampled when `memwrite`=1 on rising edge:
  - In-order: compare against entry `match_cnt` only. Address equal, data equal → `match_cnt`+1. Address equal, data differ → FAIL, code 1, capture addr/data. Other addresses ignored.
  - Any-order: candidate = lowest-index entry with hit bit clear and address equal. Data equal → set hit bit, `match_cnt`+1. Data differ → FAIL, code 1. Address matching only already-hit entries → ignored.
  - `match_cnt` reaching NUM_CHECKS → PASS.
- Timeout counter increments every RUN cycle; when it equals TIMEOUT-1 with no completion that cycle → FAIL, code 2, `fail_addr`/`fail_data` = 0.
- Simultaneous: completing write on timeout-expiry cycle → PASS wins; mismatch on timeout cycle → code 1.
- PASS/FAIL sticky until `start` or `reset`. Reset mid-RUN → IDLE, everything cleared.
- `done` = `pass` | `fail`; `pass`, `fail` mutually exclusive.

## Timing
- All outputs registered; verdict visible the cycle after the deciding write's edge.
- `match_cnt` updates the cycle after each matching write.
- `start` edge: first write checked is the one at the next rising edge.
- Max RUN duration: exactly TIMEOUT cycles from RUN entry to `fail` asserted.
- Writes while IDLE/PASS/FAIL ignored.

## Structure
- Package `mwc_pkg`: state enum (IDLE, RUN, PASS, FAIL), fail-code constants (FC_NONE, FC_MISMATCH, FC_TIMEOUT).
- One sub-module `mwc_timeout`: loadable down/up counter with clear, enable and `expired` flag, parameterised by TIMEOUT.
- Match logic (priority encoder over entries) stays in the top.

## Test plan
- NUM_CHECKS=1, IN_ORDER=1, exp (0x00, 7); start, write 0x54→0x50, then 7→0x00 → pass=1 next cycle, match_cnt=1, fail_code=0.
- NUM_CHECKS=3, IN_ORDER=1, exp (0x10,1),(0x14,2),(0x18,3); write 0x18/3 first, then 0x10/1 → match_cnt=1; write 0x14/9 → fail=1, fail_code=1, fail_addr=0x14, fail_data=9.
- Same table, IN_ORDER=0; writes 0x18/3, 0x10/1, 0x10/1 (duplicate), 0x14/2 → match_cnt steps 1,2,2,3, pass=1.
- TIMEOUT=16, no writes → fail=1, fail_code=2 exactly 16 cycles after RUN entry; completing write on cycle 16 → pass instead.
- Reset asserted mid-RUN with match_cnt=2 → all outputs 0 next cycle, writes ignored until start; start from FAIL → RUN with cleared status.

Source files
------------

// File: rtl/mwc_pkg.sv
// Shared definitions for the memory-write checker: FSM state encoding and
// failure codes reported on fail_code.
package mwc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t PASS = 2'd2;
  localparam state_t FAIL = 2'd3;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;

endpackage

// File: rtl/mwc_timeout.sv
// RUN-cycle counter for the write checker; o_expired flags the last allowed
// cycle (count == TIMEOUT-1) so the verdict lands exactly TIMEOUT cycles in.
module mwc_timeout #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt;

  assign o_expired = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Data-memory write-port monitor: matches core writes against a latched table
// of expected address/data pairs and reports a sticky PASS/FAIL verdict.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_CHECKS = 4,
  parameter int IN_ORDER   = 1,
  parameter int TIMEOUT    = 4096
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                memwrite,
  input  logic [ADDR_W-1:0]                   dataadr,
  input  logic [DATA_W-1:0]                   writedata,
  input  logic [NUM_CHECKS*ADDR_W-1:0]        exp_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0]        exp_data,
  output logic                                done,
  output logic                                pass,
  output logic                                fail,
  output logic [1:0]                          fail_code,
  output logic [ADDR_W-1:0]                   fail_addr,
  output logic [DATA_W-1:0]                   fail_data,
  output logic [$clog2(NUM_CHECKS+1)-1:0]     match_cnt
);

  localparam int MC_W = $clog2(NUM_CHECKS + 1);
  localparam int IW   = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  state_t                       r_state;
  logic [NUM_CHECKS*ADDR_W-1:0] r_exp_addr;
  logic [NUM_CHECKS*DATA_W-1:0] r_exp_data;
  logic [NUM_CHECKS-1:0]        r_hit;
  logic [MC_W-1:0]              r_match_cnt;
  logic [1:0]                   r_fail_code;
  logic [ADDR_W-1:0]            r_fail_addr;
  logic [DATA_W-1:0]            r_fail_data;

  logic          w_start;
  logic          w_expired;
  logic          w_cand_valid;
  logic [IW-1:0] w_cand_idx;
  logic          w_cand_data_ok;
  logic          w_write;
  logic          w_complete;

  assign w_start = start && (r_state != RUN);

  mwc_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_start),
    .i_enable  (r_state == RUN),
    .o_expired (w_expired)
  );

  // Priority encoder: descending scan so the lowest eligible entry wins.
  // In-order mode only the entry at match_cnt is eligible.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    w_cand_valid   = 1'b0;
    w_cand_idx     = '0;
    w_cand_data_ok = 1'b0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (((IN_ORDER != 0) ? (MC_W'(i) == r_match_cnt) : !r_hit[i]) &&
          (r_exp_addr[i*ADDR_W +: ADDR_W] == dataadr)) begin
        w_cand_valid   = 1'b1;
        w_cand_idx     = IW'(i);
        w_cand_data_ok = (r_exp_data[i*DATA_W +: DATA_W] == writedata);
      end
    end
  end

  assign w_write    = (r_state == RUN) && memwrite && w_cand_valid;
  assign w_complete = w_write && w_cand_data_ok &&
                      (r_match_cnt == MC_W'(NUM_CHECKS - 1));

  // NOTE: the expected table is plain storage, loaded on start and never reset.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_exp_addr <= exp_addr;
      r_exp_data <= exp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hit       <= '0;
      r_match_cnt <= '0;
      r_fail_code <= FC_NONE;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else if (r_state == RUN) begin
      // A deciding write outranks timeout expiry in the same cycle.
      if (w_write && !w_cand_data_ok) begin
        r_state     <= FAIL;
        r_fail_code <= FC_MISMATCH;
        r_fail_addr <= dataadr;
        r_fail_data <= writedata;
      end else begin
        if (w_write) begin
          r_hit[w_cand_idx] <= 1'b1;
          r_match_cnt       <= r_match_cnt + 1'b1;
        end
        if (w_complete) begin
          r_state <= PASS;
        end else if (w_expired) begin
          r_state     <= FAIL;
          r_fail_code <= FC_TIMEOUT;
        end
      end
    end else if (start) begin
      r_state     <= RUN;
      r_hit       <= '0;
      r_match_cnt <= '0;
      r_fail_code <= FC_NONE;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end
  end

  assign pass      = (r_state == PASS);
  assign fail      = (r_state == FAIL);
  assign done      = pass | fail;
  assign fail_code = r_fail_code;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;
  assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: an in-order and an any-order instance share one
// stimulus stream and are each compared against a table-driven reference model.
module tb_mem_write_checker;

  localparam int N  = 3;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, memwrite;
  logic [31:0]   dataadr, writedata;
  logic [N*32-1:0] exp_addr, exp_data;

  logic        d0, p0, f0, d1, p1, f1;
  logic [1:0]  fc0, fc1, mc0, mc1;
  logic [31:0] fa0, fd0, fa1, fd1;

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(N), .IN_ORDER(1), .TIMEOUT(TO)) dut_io (
    .clk(clk), .reset(reset), .start(start), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .exp_addr(exp_addr), .exp_data(exp_data), .done(d0), .pass(p0),
    .fail(f0), .fail_code(fc0), .fail_addr(fa0), .fail_data(fd0), .match_cnt(mc0));

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(N), .IN_ORDER(0), .TIMEOUT(TO)) dut_ao (
    .clk(clk), .reset(reset), .start(start), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .exp_addr(exp_addr), .exp_data(exp_data), .done(d1), .pass(p1),
    .fail(f1), .fail_code(fc1), .fail_addr(fa1), .fail_data(fd1), .match_cnt(mc1));

  // Reference model, index 0 = in-order instance, 1 = any-order instance.
  bit          m_run[2], m_pass[2], m_fail[2];
  int          m_code[2], m_cnt[2], m_cyc[2];
  logic [31:0] m_fa[2], m_fd[2];
  bit          m_hit[2][N];
  logic [31:0] m_ta[2][N], m_td[2][N];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_step(input int m, input bit rst, input bit st, input bit we,
                            input logic [31:0] a, input logic [31:0] d);
    int cand;
    if (rst) begin
      m_run[m] = 0; m_pass[m] = 0; m_fail[m] = 0; m_code[m] = 0;
      m_fa[m] = 0; m_fd[m] = 0; m_cnt[m] = 0;
      return;
    end
    if (!m_run[m]) begin
      if (st) begin
        m_run[m] = 1; m_pass[m] = 0; m_fail[m] = 0; m_code[m] = 0;
        m_fa[m] = 0; m_fd[m] = 0; m_cnt[m] = 0; m_cyc[m] = 0;
        for (int k = 0; k < N; k++) begin
          m_hit[m][k] = 0;
          m_ta[m][k]  = exp_addr[k*32 +: 32];
          m_td[m][k]  = exp_data[k*32 +: 32];
        end
      end
      return;
    end
    m_cyc[m]++;
    cand = -1;
    if (we) begin
      if (m == 0) begin
        if (a == m_ta[m][m_cnt[m]]) cand = m_cnt[m];
      end else begin
        for (int k = N - 1; k >= 0; k--)
          if (!m_hit[m][k] && a == m_ta[m][k]) cand = k;
      end
    end
    if (cand >= 0) begin
      if (d == m_td[m][cand]) begin
        m_hit[m][cand] = 1;
        m_cnt[m]++;
        if (m_cnt[m] == N) begin
          m_pass[m] = 1; m_run[m] = 0;
          return;
        end
      end else begin
        m_fail[m] = 1; m_code[m] = 1; m_fa[m] = a; m_fd[m] = d; m_run[m] = 0;
        return;
      end
    end
    if (m_cyc[m] == TO) begin
      m_fail[m] = 1; m_code[m] = 2; m_run[m] = 0;
    end
  endtask

  task automatic check_dut(input int m, input string nm, input logic dn, input logic p,
                           input logic f, input logic [1:0] fc, input logic [31:0] fa,
                           input logic [31:0] fd, input logic [1:0] mc);
    chk({nm, "_done"}, 32'(dn), 32'(m_pass[m] | m_fail[m]));
    chk({nm, "_pass"}, 32'(p), 32'(m_pass[m]));
    chk({nm, "_fail"}, 32'(f), 32'(m_fail[m]));
    chk({nm, "_fail_code"}, 32'(fc), m_code[m]);
    chk({nm, "_fail_addr"}, fa, m_fa[m]);
    chk({nm, "_fail_data"}, fd, m_fd[m]);
    chk({nm, "_match_cnt"}, 32'(mc), m_cnt[m]);
  endtask

  task automatic tick(input bit rst, input bit st, input bit we,
                      input logic [31:0] a, input logic [31:0] d);
    reset = rst; start = st; memwrite = we; dataadr = a; writedata = d;
    @(posedge clk);
    #1;
    model_step(0, rst, st, we, a, d);
    model_step(1, rst, st, we, a, d);
    check_dut(0, "io", d0, p0, f0, fc0, fa0, fd0, mc0);
    check_dut(1, "ao", d1, p1, f1, fc1, fa1, fd1, mc1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    exp_addr = {32'h18, 32'h14, 32'h10};
    exp_data = {32'd3, 32'd2, 32'd1};

    // Reset state
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("rst_done", 32'(d0), 0);
    chk("rst_match_cnt", 32'(mc1), 0);

    // Out-of-order write ignored in-order, then a data mismatch
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 32'h18, 32'd3);
    tick(0, 0, 1, 32'h10, 32'd1);
    chk("io_cnt_after_two", 32'(mc0), 1);
    chk("ao_cnt_after_two", 32'(mc1), 2);
    tick(0, 0, 1, 32'h14, 32'd9);
    chk("io_mismatch_fail", 32'(f0), 1);
    chk("io_mismatch_code", 32'(fc0), 1);
    chk("io_mismatch_addr", fa0, 32'h14);
    chk("io_mismatch_data", fd0, 32'd9);

    // Restart from FAIL; any-order tolerates a duplicate write
    tick(0, 1, 0, 0, 0);
    chk("restart_cleared", 32'(d0), 0);
    tick(0, 0, 1, 32'h18, 32'd3);
    tick(0, 0, 1, 32'h10, 32'd1);
    tick(0, 0, 1, 32'h10, 32'd1);
    chk("ao_dup_cnt", 32'(mc1), 2);
    tick(0, 0, 1, 32'h14, 32'd2);
    chk("ao_pass", 32'(p1), 1);
    chk("ao_pass_cnt", 32'(mc1), 3);
    chk("io_partial_cnt", 32'(mc0), 2);
    idle(12);
    chk("io_late_timeout", 32'(fc0), 2);

    // Timeout exactly TO cycles after RUN entry
    tick(0, 1, 0, 0, 0);
    idle(TO - 1);
    chk("io_no_fail_early", 32'(f0), 0);
    chk("ao_no_fail_early", 32'(f1), 0);
    idle(1);
    chk("io_timeout_fail", 32'(f0), 1);
    chk("io_timeout_code", 32'(fc0), 2);
    chk("ao_timeout_code", 32'(fc1), 2);
    chk("io_timeout_addr", fa0, 0);

    // Completing write on the expiry cycle wins
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 32'h10, 32'd1);
    tick(0, 0, 1, 32'h14, 32'd2);
    idle(TO - 3);
    tick(0, 0, 1, 32'h18, 32'd3);
    chk("io_pass_on_expiry", 32'(p0), 1);
    chk("ao_pass_on_expiry", 32'(p1), 1);
    chk("io_no_fail_on_expiry", 32'(f0), 0);

    // Reset mid-RUN clears everything; writes ignored until start
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 32'h10, 32'd1);
    tick(0, 0, 1, 32'h14, 32'd2);
    chk("io_cnt_before_reset", 32'(mc0), 2);
    tick(1, 0, 0, 0, 0);
    chk("reset_cnt", 32'(mc0), 0);
    chk("reset_done", 32'(d1), 0);
    tick(0, 0, 1, 32'h18, 32'd3);
    chk("idle_write_ignored", 32'(mc1), 0);

    // Randomized tables and write streams
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < N; k++) begin
        exp_addr[k*32 +: 32] = 32'h10 + 32'(4 * $urandom_range(0, 3));
        exp_data[k*32 +: 32] = 32'($urandom_range(0, 3));
      end
      tick(0, 1, 0, 0, 0);
      for (int c = 0; c < 20; c++) begin
        int   sel;
        logic [31:0] a;
        sel = $urandom_range(0, 4);
        a = (sel == 4) ? 32'h54 : 32'h10 + 32'(4 * sel);
        tick($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
             1'($urandom_range(0, 1)), a, 32'($urandom_range(0, 3)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
